cnt4_fsm: RTL and testbench
===========================

// Module: cnt4_fsm
// PURPOSE
//  Registered up-counter with run/done control that consumes fadder (full-adder) cells.
//  A WIDTH-bit ripple chain of fadder instances computes cnt+1; this block registers the sum.
//  The chain's MSB carry-out is the wrap/terminal indication.
//  Top-level sequential stage of the 4-bit counter synthesis flow.
// PARAMETERS
//  WIDTH   4      counter width = number of fadder instances in the ripple chain
// PORTS
//  clk_i        in   1      clock, rising edge
//  rst_i        in   1      asynchronous reset, active-high
//  en_i         in   1      count enable (RUN state only)
//  start_i      in   1      start/restart request
//  mode_i       in   1      0 = free-run (wrap), 1 = one-shot (stop at terminal)
//  clr_i        in   1      synchronous clear
//  load_i       in   1      synchronous load strobe
//  load_val_i   in   WIDTH  load value
//  cnt_o        out  WIDTH  registered count
//  wrap_o       out  1      registered 1-cycle pulse, free-run wrap occurred
//  busy_o       out  1      1 while state == RUN
//  done_o       out  1      1 while state == DONE
// BEHAVIOUR
//  - Reset (async, any time incl. mid-count):
//    cnt_o=0, state=IDLE, wrap_o=0, busy_o=0, done_o=0.
//  - Adder: fadder chain with a=cnt_o, b=0, carry-in=1; sum -> next count; cout = carry out of bit WIDTH-1.
//    cout=1 only when cnt_o = all-ones.
//  - Per-cycle priority: clr_i > load_i > start_i > counting.
//  - clr_i: cnt<=0, state<=IDLE.
//  - load_i: cnt<=load_val_i.
//    State unchanged, except DONE->IDLE.
//  - FSM states:
//    IDLE: cnt holds. start_i -> RUN; cnt unchanged.
//    RUN, en_i=0: cnt holds.
//    RUN, en_i=1, cout=0: cnt<=sum.
//    RUN, en_i=1, cout=1, mode_i=0: cnt<=0 (sum), stay RUN; wrap_o=1 next cycle.
//    RUN, en_i=1, cout=1, mode_i=1: cnt holds all-ones, state<=DONE; wrap_o stays 0.
//    DONE: cnt holds. start_i -> cnt<=0, state<=RUN.
//  - mode_i is sampled every cycle; only its value in the terminal cycle matters.
//  - start_i while in RUN has no effect.
//  - Outputs are registered/state-decoded.
//    Latency: one clock from input to cnt_o/wrap_o/done_o.
//  - wrap_o is exactly one cycle wide.
//    Asserted in the same cycle cnt_o first shows 0 after wrap.
// CONFIGURATION
//  CNT4_UPDOWN_EN defined:
//    - Adds input dir_i (1 bit).
//    - dir_i=0: up-count, as above.
//    - dir_i=1: b=all-ones, carry-in=0 (adds -1).
//    - Terminal when cout=0 (cnt_o = 0).
//    - Free-run down: 0 -> all-ones with wrap_o pulse.
//    - One-shot down: holds 0 and enters DONE.
//    - DONE restart via start_i when last dir_i=1 loads all-ones instead of 0.
//  CNT4_UPDOWN_EN undefined:
//    - No dir_i port; up-count only; b tied to 0.
// TESTING
//  1. Free-run: rst, start_i, en_i=1 for 17 cycles.
//     -> cnt_o 1..F,0,1; wrap_o=1 exactly in the cycle cnt_o=0; busy_o=1.
//  2. One-shot: mode_i=1, start, en_i=1 for 20 cycles.
//     -> cnt_o stops at F; done_o=1, busy_o=0, wrap_o never 1.
//  3. Reset mid-count: at cnt_o=5, pulse rst_i between edges.
//     -> cnt_o=0 and busy_o=0 immediately, without waiting for a clock edge.
//  4. Load/priority:
//     - load_val_i=E in RUN, en_i=1 -> cnt_o E,F,0 with wrap_o.
//     - clr_i and load_i together -> cnt_o=0, IDLE.
//  5. Pause and restart:
//     - en_i=0 for 3 cycles at cnt_o=7 -> holds 7.
//     - From DONE, start_i -> cnt_o=0, busy_o=1.
//  6. With CNT4_UPDOWN_EN:
//     - dir_i=1, free-run from 0 -> F with wrap_o pulse.
//     - One-shot from 2 -> 1,0, then DONE.

Source files
------------

// File: rtl/cnt4_fsm_if.sv
// Control/status bundle for cnt4_fsm; dir_i exists only when CNT4_UPDOWN_EN is defined.
// master drives the controls, slave is the counter side.
interface cnt4_fsm_if #(
  parameter int WIDTH = 4
);
  logic             en_i;
  logic             start_i;
  logic             mode_i;
  logic             clr_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
`ifdef CNT4_UPDOWN_EN
  logic             dir_i;
`endif
  logic [WIDTH-1:0] cnt_o;
  logic             wrap_o;
  logic             busy_o;
  logic             done_o;

  modport master (
`ifdef CNT4_UPDOWN_EN
    output dir_i,
`endif
    output en_i, start_i, mode_i, clr_i, load_i, load_val_i,
    input  cnt_o, wrap_o, busy_o, done_o
  );

  modport slave (
`ifdef CNT4_UPDOWN_EN
    input  dir_i,
`endif
    input  en_i, start_i, mode_i, clr_i, load_i, load_val_i,
    output cnt_o, wrap_o, busy_o, done_o
  );
endinterface

// File: rtl/cnt4_fsm.sv
// Run/done controlled counter whose increment comes from a ripple chain of fadder cells.
// Optional feature macro: CNT4_UPDOWN_EN adds dir_i for down-counting.
module fadder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module cnt4_fsm #(
  parameter int WIDTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  cnt4_fsm_if.slave     bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic             wrap, wrap_nxt;
  logic             dir;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic             terminal;

`ifdef CNT4_UPDOWN_EN
  assign dir = bus.dir_i;
`else
  assign dir = 1'b0;
`endif

  // Up: cnt + 0 + 1. Down: cnt + all-ones + 0, i.e. cnt - 1.
  assign addend   = {WIDTH{dir}};
  assign carry[0] = ~dir;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fadder u_fa (
      .a  (cnt[i]),
      .b  (addend[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // Up terminal is carry-out set (all-ones); down terminal is no borrow-free carry (zero).
  assign terminal = carry[WIDTH] ^ dir;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      wrap  <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wrap_nxt  = 1'b0;
    if (bus.clr_i) begin
      cnt_nxt   = '0;
      state_nxt = IDLE;
    end else if (bus.load_i) begin
      cnt_nxt = bus.load_val_i;
      if (state == DONE) state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) state_nxt = RUN;
        end
        RUN: begin
          if (bus.en_i) begin
            if (!terminal) begin
              cnt_nxt = sum;
            end else if (!bus.mode_i) begin
              cnt_nxt  = sum;
              wrap_nxt = 1'b1;
            end else begin
              state_nxt = DONE;
            end
          end
        end
        DONE: begin
          // A restart begins from the far end for the current direction.
          if (bus.start_i) begin
            cnt_nxt   = {WIDTH{dir}};
            state_nxt = RUN;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.cnt_o  = cnt;
  assign bus.wrap_o = wrap;
  assign bus.busy_o = (state == RUN);
  assign bus.done_o = (state == DONE);
endmodule

// File: tb/tb_cnt4_fsm.sv
// Directed self-checking bench for cnt4_fsm; the CNT4_UPDOWN_EN section runs only when
// the macro is defined.
module tb_cnt4_fsm;
  logic clk;
  logic rst;
  int   assert_count;
  int   fail_count;

  cnt4_fsm_if #(.WIDTH(4)) bus ();

  cnt4_fsm #(.WIDTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic start, input logic mode,
                               input logic clr, input logic load, input logic [3:0] val);
    bus.en_i       = en;
    bus.start_i    = start;
    bus.mode_i     = mode;
    bus.clr_i      = clr;
    bus.load_i     = load;
    bus.load_val_i = val;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [3:0] c, input logic w,
                            input logic b, input logic d);
    checkOutput({tag, ".cnt"},  32'(bus.cnt_o),  32'(c));
    checkOutput({tag, ".wrap"}, 32'(bus.wrap_o), 32'(w));
    checkOutput({tag, ".busy"}, 32'(bus.busy_o), 32'(b));
    checkOutput({tag, ".done"}, 32'(bus.done_o), 32'(d));
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    rst = 1'b1;
`ifdef CNT4_UPDOWN_EN
    bus.dir_i = 1'b0;
`endif
    applyStimulus(0, 0, 0, 0, 0, 4'h0);
    #3;
    checkState("reset", 4'h0, 0, 0, 0);
    #1 rst = 1'b0;

    // Free-run: 1..F, 0 (with wrap), 1
    applyStimulus(1, 1, 0, 0, 0, 4'h0);
    tick();
    checkState("fr_start", 4'h0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 4'h0);
    for (int i = 1; i <= 17; i++) begin
      tick();
      checkState($sformatf("fr%0d", i), 4'(i % 16), (i == 16), 1, 0);
    end

    // One-shot: stops at F and enters DONE, never wraps
    applyStimulus(0, 0, 0, 1, 0, 4'h0);
    tick();
    checkState("clr", 4'h0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 4'h0);
    tick();
    applyStimulus(1, 0, 1, 0, 0, 4'h0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      checkState($sformatf("os%0d", i), (i < 15) ? 4'(i) : 4'hF, 0, (i < 16), (i >= 16));
    end

    // Restart from DONE, count to 5, then asynchronous reset between edges
    applyStimulus(1, 1, 0, 0, 0, 4'h0);
    tick();
    checkState("restart", 4'h0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 4'h0);
    repeat (5) tick();
    checkState("pre_rst", 4'h5, 0, 1, 0);
    #2 rst = 1'b1;
    #1;
    checkState("async_rst", 4'h0, 0, 0, 0);
    #1 rst = 1'b0;
    tick();
    checkState("post_rst", 4'h0, 0, 0, 0);

    // Load in RUN overrides counting, then wraps from F
    applyStimulus(1, 1, 0, 0, 0, 4'h0);
    tick();
    applyStimulus(1, 0, 0, 0, 1, 4'hE);
    tick();
    checkState("load_e", 4'hE, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 4'h0);
    tick();
    checkState("load_f", 4'hF, 0, 1, 0);
    tick();
    checkState("load_wrap", 4'h0, 1, 1, 0);
    tick();
    checkState("load_after", 4'h1, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 1, 4'h9);
    tick();
    checkState("clr_over_load", 4'h0, 0, 0, 0);

    // Pause at 7; start while running is ignored
    applyStimulus(1, 1, 0, 0, 0, 4'h0);
    tick();
    repeat (7) tick();
    checkState("run7", 4'h7, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkState($sformatf("pause%0d", i), 4'h7, 0, 1, 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 4'h0);
    tick();
    checkState("resume", 4'h8, 0, 1, 0);

    // Load while DONE returns to IDLE
    applyStimulus(1, 0, 1, 0, 1, 4'hF);
    tick();
    applyStimulus(1, 0, 1, 0, 0, 4'h0);
    tick();
    checkState("done_again", 4'hF, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 4'h3);
    tick();
    checkState("load_done", 4'h3, 0, 0, 0);

`ifdef CNT4_UPDOWN_EN
    // Down free-run from 0 wraps to F
    bus.dir_i = 1'b1;
    applyStimulus(0, 0, 0, 1, 0, 4'h0);
    tick();
    applyStimulus(1, 1, 0, 0, 0, 4'h0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 4'h0);
    tick();
    checkState("dn_wrap", 4'hF, 1, 1, 0);
    tick();
    checkState("dn_e", 4'hE, 0, 1, 0);
    // Down one-shot from 2
    applyStimulus(1, 0, 1, 0, 1, 4'h2);
    tick();
    applyStimulus(1, 0, 1, 0, 0, 4'h0);
    tick();
    checkState("dn_1", 4'h1, 0, 1, 0);
    tick();
    checkState("dn_0", 4'h0, 0, 1, 0);
    tick();
    checkState("dn_done", 4'h0, 0, 0, 1);
    applyStimulus(1, 1, 1, 0, 0, 4'h0);
    tick();
    checkState("dn_restart", 4'hF, 0, 1, 0);
    bus.dir_i = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
